// File: rtl/reg_file_sb.sv
// Integer register file with optional write-to-read bypass, hardwired zero
// register and a per-register pending-write scoreboard for the issue stage.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok,
    output logic [ADDR_W:0]          busy_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic            wr_live;
    logic            rsv_zero;
    logic            rsv_match;
    logic            rsv_take;
    logic [ADDR_W:0] cnt_inc;
    logic [ADDR_W:0] cnt_dec;

    // A write to the hardwired zero register behaves as if it never happened.
    assign wr_live   = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
    assign rsv_zero  = (ZERO_REG != 0) && (rsv_addr == '0);
    assign rsv_match = wr_live && (wr_addr == rsv_addr);

    assign rsv_ok   = rsv_en && (rsv_zero || !busy[rsv_addr] || rsv_match);
    assign rsv_take = rsv_ok && !rsv_zero;

    // The count tracks set busy bits: a same-register reserve+write leaves the
    // bit set, and a reserve of A alongside a clearing write of B cancels out.
    assign cnt_inc = (ADDR_W+1)'(rsv_take && !busy[rsv_addr]);
    assign cnt_dec = (ADDR_W+1)'(wr_live && busy[wr_addr] &&
                                 !(rsv_take && rsv_addr == wr_addr));

    // NOTE: the data array is reset too, because architectural registers must
    // read 0 after reset; this prevents mapping it onto a reset-less RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            // NOTE: non-blocking order matters here: a same-cycle reservation
            // is written after the writeback clear, so the set wins.
            if (wr_live) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            if (rsv_take) busy[rsv_addr] <= 1'b1;
            busy_cnt <= busy_cnt + cnt_inc - cnt_dec;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        logic              is_fwd;

        assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign is_fwd  = (BYPASS != 0) && wr_live && (wr_addr == addr);

        // NOTE: plain continuous assigns give every output a value on every
        // path, so no latch can be inferred for the read mux.
        assign rd_data[k*DATA_W +: DATA_W] = is_zero ? '0 :
                                             is_fwd  ? wr_data : regs[addr];
        assign rd_busy[k] = !is_zero && !is_fwd && busy[addr];
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a bypassing and a non-bypassing instance share the
// same stimulus and are compared against an array-based model of the file.
module tb_reg_file_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [2*AW-1:0] rd_addr = '0;
    logic [2*DW-1:0] rd_data, rd_data_nb;
    logic [1:0]      rd_busy, rd_busy_nb;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            rsv_en = 1'b0;
    logic [AW-1:0]   rsv_addr = '0;
    logic            rsv_ok, rsv_ok_nb;
    logic [AW:0]     busy_cnt, busy_cnt_nb;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_nb), .busy_cnt(busy_cnt_nb)
    );

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [DW-1:0] exp_data(logic [AW-1:0] a, bit bp);
        if (a == 0) return '0;
        if (bp && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(logic [AW-1:0] a, bit bp);
        if (a == 0) return 1'b0;
        if (bp && wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit exp_ok();
        return rsv_en && (rsv_addr == 0 || !m_busy[rsv_addr] ||
                          (wr_en && wr_addr == rsv_addr));
    endfunction

    // Drive one cycle's inputs shortly after an edge, then settle.
    task automatic apply(input bit we, input int wa, input logic [DW-1:0] wd,
                         input bit re, input int ra, input int a0, input int a1);
        wr_en    = we;
        wr_addr  = AW'(wa);
        wr_data  = wd;
        rsv_en   = re;
        rsv_addr = AW'(ra);
        rd_addr  = {AW'(a1), AW'(a0)};
        #2;
    endtask

    // Advance the model by the architectural rules, then cross the edge.
    task automatic tick();
        bit ok;
        ok = exp_ok();
        if (rst) begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (ok && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int a0, input int a1);
        apply(1'b0, 0, '0, 1'b0, 0, a0, a1);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (busy_cnt !== '0 || rd_data !== '0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_init: cnt=%0d data=%h busy=%b required 0/0/0", busy_cnt, rd_data, rd_busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        apply(1'b1, 3, 32'h55, 1'b0, 0, 3, 3);
        tick();
        apply(1'b0, 0, '0, 1'b1, 3, 3, 3);
        tick();
        idle(3, 3);
        checks++;
        if (rd_data[DW-1:0] !== 32'h55 || rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
            errors++;
            $display("FAIL reset_setup: data=%h busy=%b cnt=%0d required 55/1/1", rd_data[DW-1:0], rd_busy[0], busy_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== 2'b00 || busy_cnt !== '0 || busy_cnt_nb !== '0) begin
            errors++;
            $display("FAIL reset_async: data=%h busy=%b cnt=%0d required 0/0/0", rd_data, rd_busy, busy_cnt);
        end
        model_clear();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_bypass();
        apply(1'b1, 5, 32'h11, 1'b0, 0, 0, 0);
        tick();
        apply(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 5, 5);
        checks++;
        if (rd_data !== {2{32'hDEADBEEF}}) begin
            errors++;
            $display("FAIL bypass_fwd: got %h required %h", rd_data, {2{32'hDEADBEEF}});
        end
        checks++;
        if (rd_data_nb !== {2{32'h11}}) begin
            errors++;
            $display("FAIL nobypass_same: got %h required %h", rd_data_nb, {2{32'h11}});
        end
        tick();
        idle(5, 5);
        checks++;
        if (rd_data_nb !== {2{32'hDEADBEEF}}) begin
            errors++;
            $display("FAIL nobypass_next: got %h required %h", rd_data_nb, {2{32'hDEADBEEF}});
        end
    endtask

    task automatic test_zero();
        apply(1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 0, 0);
        tick();
        apply(1'b0, 0, '0, 1'b1, 0, 0, 0);
        checks++;
        if (rd_data !== '0 || rd_data_nb !== '0 || rsv_ok !== 1'b1 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL zero_reg: data=%h ok=%b busy=%b required 0/1/0", rd_data, rsv_ok, rd_busy);
        end
        tick();
        idle(0, 0);
        checks++;
        if (busy_cnt !== '0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL zero_cnt: cnt=%0d busy=%b required 0/0", busy_cnt, rd_busy);
        end
    endtask

    task automatic test_scoreboard();
        apply(1'b0, 0, '0, 1'b1, 7, 7, 0);
        checks++;
        if (rsv_ok !== 1'b1) begin
            errors++;
            $display("FAIL sb_reserve: ok=%b required 1", rsv_ok);
        end
        tick();
        apply(1'b0, 0, '0, 1'b1, 7, 7, 0);
        checks++;
        if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1 || rsv_ok !== 1'b0) begin
            errors++;
            $display("FAIL sb_busy: busy=%b cnt=%0d ok=%b required 1/1/0", rd_busy[0], busy_cnt, rsv_ok);
        end
        tick();
        apply(1'b1, 7, 32'h1234, 1'b0, 0, 0, 0);
        tick();
        idle(7, 7);
        checks++;
        if (rd_busy !== 2'b00 || busy_cnt !== '0 || rd_data[DW-1:0] !== 32'h1234) begin
            errors++;
            $display("FAIL sb_clear: busy=%b cnt=%0d data=%h required 0/0/1234", rd_busy, busy_cnt, rd_data[DW-1:0]);
        end
    endtask

    task automatic test_simultaneous();
        apply(1'b0, 0, '0, 1'b1, 9, 0, 0);
        tick();
        apply(1'b1, 9, 32'hA5, 1'b1, 9, 0, 0);
        checks++;
        if (rsv_ok !== 1'b1) begin
            errors++;
            $display("FAIL sim_same_ok: ok=%b required 1", rsv_ok);
        end
        tick();
        idle(9, 9);
        checks++;
        if (rd_data[DW-1:0] !== 32'hA5 || rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
            errors++;
            $display("FAIL sim_same: data=%h busy=%b cnt=%0d required a5/1/1", rd_data[DW-1:0], rd_busy[0], busy_cnt);
        end
        apply(1'b1, 9, 32'h5A, 1'b1, 4, 0, 0);
        tick();
        idle(4, 9);
        checks++;
        if (busy_cnt !== 6'd1 || rd_busy !== 2'b01) begin
            errors++;
            $display("FAIL sim_cross: cnt=%0d busy=%b required 1/01", busy_cnt, rd_busy);
        end
        apply(1'b1, 4, 32'h44, 1'b0, 0, 0, 0);
        tick();
    endtask

    task automatic test_fill();
        int bad_ok = 0;
        for (int i = 1; i < DEPTH; i++) begin
            apply(1'b0, 0, '0, 1'b1, i, 0, 0);
            if (rsv_ok !== 1'b1) bad_ok++;
            tick();
        end
        idle(0, 0);
        checks++;
        if (busy_cnt !== 6'd31 || bad_ok != 0) begin
            errors++;
            $display("FAIL fill_cnt: cnt=%0d rejects=%0d required 31/0", busy_cnt, bad_ok);
        end
        bad_ok = 0;
        for (int i = 1; i < DEPTH; i++) begin
            apply(1'b0, 0, '0, 1'b1, i, 0, 0);
            if (rsv_ok !== 1'b0) bad_ok++;
            tick();
        end
        apply(1'b0, 0, '0, 1'b1, 0, 0, 0);
        checks++;
        if (bad_ok != 0 || rsv_ok !== 1'b1 || busy_cnt !== 6'd31) begin
            errors++;
            $display("FAIL fill_full: accepts=%0d ok0=%b cnt=%0d required 0/1/31", bad_ok, rsv_ok, busy_cnt);
        end
        tick();
        for (int i = 1; i < DEPTH; i++) begin
            apply(1'b1, i, DW'(i * 3), 1'b0, 0, 0, 0);
            tick();
        end
        idle(31, 1);
        checks++;
        if (busy_cnt !== '0 || rd_busy !== 2'b00 || rd_data !== {32'd3, 32'd93}) begin
            errors++;
            $display("FAIL fill_drain: cnt=%0d busy=%b data=%h required 0/0/%h", busy_cnt, rd_busy, rd_data, {32'd3, 32'd93});
        end
    endtask

    task automatic test_random();
        int a0, a1, ra, wa;
        for (int n = 0; n < 400; n++) begin
            wa = $urandom_range(0, 7);
            ra = $urandom_range(0, 7);
            a0 = $urandom_range(0, 7);
            a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, 7));
            apply(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ra, a0, a1);
            checks++;
            if (rd_data !== {exp_data(AW'(a1), 1'b1), exp_data(AW'(a0), 1'b1)} ||
                rd_busy !== {exp_busy(AW'(a1), 1'b1), exp_busy(AW'(a0), 1'b1)}) begin
                errors++;
                $display("FAIL rand_read_byp[%0d]: data=%h busy=%b required %h/%b", n, rd_data, rd_busy,
                         {exp_data(AW'(a1), 1'b1), exp_data(AW'(a0), 1'b1)},
                         {exp_busy(AW'(a1), 1'b1), exp_busy(AW'(a0), 1'b1)});
            end
            checks++;
            if (rd_data_nb !== {exp_data(AW'(a1), 1'b0), exp_data(AW'(a0), 1'b0)} ||
                rd_busy_nb !== {exp_busy(AW'(a1), 1'b0), exp_busy(AW'(a0), 1'b0)}) begin
                errors++;
                $display("FAIL rand_read_nb[%0d]: data=%h busy=%b required %h/%b", n, rd_data_nb, rd_busy_nb,
                         {exp_data(AW'(a1), 1'b0), exp_data(AW'(a0), 1'b0)},
                         {exp_busy(AW'(a1), 1'b0), exp_busy(AW'(a0), 1'b0)});
            end
            checks++;
            if (rsv_ok !== exp_ok() || rsv_ok_nb !== exp_ok() ||
                int'(busy_cnt) != model_cnt() || int'(busy_cnt_nb) != model_cnt()) begin
                errors++;
                $display("FAIL rand_sb[%0d]: ok=%b/%b cnt=%0d/%0d required %b/%0d", n, rsv_ok, rsv_ok_nb,
                         busy_cnt, busy_cnt_nb, exp_ok(), model_cnt());
            end
            tick();
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_bypass();
        test_zero();
        test_scoreboard();
        test_simultaneous();
        test_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
